// File: rtl/bp_io_cmd_arbiter_pkg.sv
// Shared types and helpers for the BedRock I/O command arbiter.
package bp_io_cmd_arbiter_pkg;

    // Arbiter control states: waiting to pick a winner, or holding a grant.
    typedef enum logic {
        e_idle   = 1'b0,
        e_locked = 1'b1
    } bp_io_arb_state_e;

    // Largest supported requester count; route entries never need more bits.
    localparam int max_req_lp = 8;

    // clog2 that never returns 0, so a one-entry thing still gets a 1-bit index.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the value n itself (0..n inclusive).
    function automatic int bsg_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of one route FIFO entry (a requester id).
    function automatic int route_id_width(input int num_req);
        return safe_clog2(num_req);
    endfunction

endpackage

// File: rtl/bp_io_arb_route_fifo.sv
// Small in-order FIFO of requester ids, one entry per outstanding command.
// The head entry names the owner of the next response to arrive.
module bp_io_arb_route_fifo
    import bp_io_cmd_arbiter_pkg::*;
#(
    parameter int depth_p = 4,
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int ptr_width_lp   = safe_clog2(depth_p);
    localparam int count_width_lp = bsg_width(depth_p);

    logic [width_p-1:0]        mem_q [depth_p];
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      push_ok;
    logic                      pop_ok;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(depth_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == count_width_lp'(depth_p));
    assign empty_o = (count_q == '0);
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every entry.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_io_cmd_arbiter.sv
// Shares one BedRock I/O command/response port between num_req_p requesters.
// Single-beat commands are arbitrated with a grant lock, limited by the
// io_noc credit count, and responses are steered back in issue order.
// Build option: define BP_IO_CMD_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no round-robin pointer); default is round-robin.
module bp_io_cmd_arbiter
    import bp_io_cmd_arbiter_pkg::*;
#(
    parameter int  num_req_p       = 2,
    parameter int  header_width_p  = 16,
    parameter int  data_width_p    = 32,
    parameter int  max_credits_p   = 4,
    localparam int lg_req_lp       = route_id_width(num_req_p),
    localparam int credit_width_lp = bsg_width(max_credits_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p*header_width_p-1:0] req_header_i,
    input  logic [num_req_p*data_width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]                req_v_i,
    output logic [num_req_p-1:0]                req_yumi_o,
    output logic [header_width_p-1:0]           req_resp_header_o,
    output logic [data_width_p-1:0]             req_resp_data_o,
    output logic [num_req_p-1:0]                req_resp_v_o,
    input  logic [num_req_p-1:0]                req_resp_ready_i,
    output logic [header_width_p-1:0]           io_cmd_header_o,
    output logic [data_width_p-1:0]             io_cmd_data_o,
    output logic                                io_cmd_v_o,
    input  logic                                io_cmd_yumi_i,
    input  logic [header_width_p-1:0]           io_resp_header_i,
    input  logic [data_width_p-1:0]             io_resp_data_i,
    input  logic                                io_resp_v_i,
    output logic                                io_resp_ready_o,
    output logic [credit_width_lp-1:0]          credits_o,
    output logic                                idle_o,
    output logic                                error_o
);

    bp_io_arb_state_e           state_q, state_d;
    logic [lg_req_lp-1:0]       winner_q, winner_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic                       error_q, error_d;

    logic [header_width_p-1:0]  hdr_arr  [num_req_p];
    logic [data_width_p-1:0]    data_arr [num_req_p];

    logic                       can_issue;
    logic                       cmd_v;
    logic                       cmd_fire;
    logic [lg_req_lp-1:0]       start_id;
    logic [num_req_p-1:0]       rot_v;
    logic                       pick_v;
    logic [lg_req_lp-1:0]       pick_id;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [lg_req_lp-1:0]       head_id;
    logic                       resp_pop;
    logic                       resp_stray;

    // Split the flat per-requester buses into indexable arrays.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
        assign hdr_arr[gi]  = req_header_i[gi*header_width_p +: header_width_p];
        assign data_arr[gi] = req_data_i[gi*data_width_p +: data_width_p];
    end

    assign can_issue = (credits_q != credit_width_lp'(max_credits_p)) && !fifo_full;

`ifdef BP_IO_CMD_ARB_FIXED_PRIO_EN
    // Loader priority: the search always starts at requester 0.
    assign start_id = '0;
`else
    logic [lg_req_lp-1:0] ptr_q, ptr_d;
    logic [lg_req_lp:0]   ptr_inc;

    assign start_id = ptr_q;
    assign ptr_inc  = {1'b0, winner_q} + 1'b1;

    // After a command issues, the search starts just past its requester.
    always_comb begin
        ptr_d = ptr_q;
        if (cmd_fire) begin
            ptr_d = (ptr_inc == (lg_req_lp+1)'(num_req_p)) ? '0 : ptr_inc[lg_req_lp-1:0];
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Rotate the valids so bit 0 is the first requester to consider.
    always_comb begin
        rot_v = '0;
        for (int s = 0; s < num_req_p; s++) begin
            if (start_id == lg_req_lp'(s)) begin
                for (int k = 0; k < num_req_p; k++) begin
                    rot_v[k] = req_v_i[(s + k) % num_req_p];
                end
            end
        end
    end

    // First valid requester in rotated order, mapped back to its real index.
    always_comb begin
        logic [lg_req_lp:0] sum;
        pick_v  = 1'b0;
        pick_id = '0;
        sum     = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!pick_v && rot_v[k]) begin
                pick_v = 1'b1;
                sum    = {1'b0, start_id} + (lg_req_lp+1)'(k);
                if (sum >= (lg_req_lp+1)'(num_req_p)) begin
                    sum = sum - (lg_req_lp+1)'(num_req_p);
                end
                pick_id = sum[lg_req_lp-1:0];
            end
        end
    end

    // Grant FSM: pick and lock a winner, then present its command until taken.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        cmd_v    = 1'b0;
        cmd_fire = 1'b0;
        case (state_q)
            e_idle: begin
                if (pick_v && can_issue) begin
                    winner_d = pick_id;
                    state_d  = e_locked;
                end
            end
            e_locked: begin
                cmd_v    = req_v_i[winner_q] && can_issue;
                cmd_fire = cmd_v && io_cmd_yumi_i;
                if (cmd_fire) begin
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // Response steering: the oldest outstanding command owns the response.
    assign resp_pop   = io_resp_v_i && !fifo_empty && req_resp_ready_i[head_id];
    assign resp_stray = io_resp_v_i && fifo_empty;

    // Credit count follows issued minus returned; stray responses only flag.
    always_comb begin
        credits_d = credits_q;
        case ({cmd_fire, resp_pop})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase
        error_d = error_q || resp_stray;
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            winner_q  <= '0;
            credits_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            credits_q <= credits_d;
            error_q   <= error_d;
        end
    end

    bp_io_arb_route_fifo #(
        .depth_p (max_credits_p),
        .width_p (lg_req_lp)
    ) route_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (cmd_fire),
        .data_i    (winner_q),
        .pop_i     (resp_pop),
        .head_o    (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Per-requester grant and response-valid strobes.
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_strobe
        assign req_yumi_o[gi]   = cmd_fire && (winner_q == lg_req_lp'(gi));
        assign req_resp_v_o[gi] = io_resp_v_i && !fifo_empty && (head_id == lg_req_lp'(gi));
    end

    // Outputs are held at zero when nothing is being presented.
    assign io_cmd_v_o        = cmd_v;
    assign io_cmd_header_o   = (state_q == e_locked) ? hdr_arr[winner_q]  : '0;
    assign io_cmd_data_o     = (state_q == e_locked) ? data_arr[winner_q] : '0;
    assign req_resp_header_o = fifo_empty ? '0 : io_resp_header_i;
    assign req_resp_data_o   = fifo_empty ? '0 : io_resp_data_i;
    assign io_resp_ready_o   = fifo_empty ? 1'b1 : req_resp_ready_i[head_id];
    assign credits_o         = credits_q;
    assign idle_o            = (credits_q == '0) && (state_q == e_idle);
    assign error_o           = error_q;

    // A locked requester must keep its command valid until it is accepted.
    a_winner_holds_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (state_q == e_locked) |-> req_v_i[winner_q]
    );

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed bench for bp_io_cmd_arbiter with a queue-based reference model.
module tb_bp_io_cmd_arbiter;

    localparam int N   = 2;
    localparam int HW  = 16;
    localparam int DW  = 32;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic [N*HW-1:0] req_header_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_v_i;
    logic [N-1:0]    req_yumi_o;
    logic [HW-1:0]   req_resp_header_o;
    logic [DW-1:0]   req_resp_data_o;
    logic [N-1:0]    req_resp_v_o;
    logic [N-1:0]    req_resp_ready_i;
    logic [HW-1:0]   io_cmd_header_o;
    logic [DW-1:0]   io_cmd_data_o;
    logic            io_cmd_v_o;
    logic            io_cmd_yumi_i;
    logic [HW-1:0]   io_resp_header_i;
    logic [DW-1:0]   io_resp_data_i;
    logic            io_resp_v_i;
    logic            io_resp_ready_o;
    logic [CW-1:0]   credits_o;
    logic            idle_o;
    logic            error_o;

    logic yumi_en;
    bit   run = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Bench-side requester/downstream state
    int pend [N];
    int seq  [N];
    int resp_pend = 0;
    int resp_seq  = 0;
    int peak = 0;
    bit y1_seen = 1'b0;
    int grant_log[$];
    int owner_log[$];

    // Reference model state
    int m_q[$];
    bit m_locked = 1'b0;
    int m_win = 0;
    int m_ptr = 0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    assign io_cmd_yumi_i = yumi_en & io_cmd_v_o;

    bp_io_cmd_arbiter #(
        .num_req_p      (N),
        .header_width_p (HW),
        .data_width_p   (DW),
        .max_credits_p  (MAX)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n_i),
        .req_header_i      (req_header_i),
        .req_data_i        (req_data_i),
        .req_v_i           (req_v_i),
        .req_yumi_o        (req_yumi_o),
        .req_resp_header_o (req_resp_header_o),
        .req_resp_data_o   (req_resp_data_o),
        .req_resp_v_o      (req_resp_v_o),
        .req_resp_ready_i  (req_resp_ready_i),
        .io_cmd_header_o   (io_cmd_header_o),
        .io_cmd_data_o     (io_cmd_data_o),
        .io_cmd_v_o        (io_cmd_v_o),
        .io_cmd_yumi_i     (io_cmd_yumi_i),
        .io_resp_header_i  (io_resp_header_i),
        .io_resp_data_i    (io_resp_data_i),
        .io_resp_v_i       (io_resp_v_i),
        .io_resp_ready_o   (io_resp_ready_o),
        .credits_o         (credits_o),
        .idle_o            (idle_o),
        .error_o           (error_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // Reference model: one pending queue of owners, a lock flag and a pointer.
    initial begin
        bit can;
        bit fire;
        bit found;
        int start;
        int idx;
        forever begin
            @(posedge clk or negedge reset_n_i);
            if (!reset_n_i) begin
                m_q.delete();
                m_locked = 1'b0;
                m_win    = 0;
                m_ptr    = 0;
                m_err    = 1'b0;
            end else begin
                can  = m_q.size() < MAX;
                fire = m_locked && bit_of(req_v_i, m_win) && can && yumi_en;
                if (io_resp_v_i) begin
                    if (m_q.size() == 0) m_err = 1'b1;
                    else if (bit_of(req_resp_ready_i, m_q[0])) void'(m_q.pop_front());
                end
                if (m_locked) begin
                    if (fire) begin
                        m_q.push_back(m_win);
                        m_locked = 1'b0;
                        m_ptr    = (m_win + 1) % N;
                    end
                end else if (req_v_i != '0 && can) begin
`ifdef BP_IO_CMD_ARB_FIXED_PRIO_EN
                    start = 0;
`else
                    start = m_ptr;
`endif
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        idx = (start + k) % N;
                        if (!found && bit_of(req_v_i, idx)) begin
                            found = 1'b1;
                            m_win = idx;
                        end
                    end
                    m_locked = 1'b1;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (run) begin
            bit            exp_v;
            logic [N-1:0]  exp_y;
            logic [N-1:0]  exp_rv;
            bit            exp_rr;
            exp_v = m_locked && bit_of(req_v_i, m_win) && (m_q.size() < MAX);
            chk("cmd_v", io_cmd_v_o, exp_v);
            if (exp_v) begin
                chk("cmd_hdr", io_cmd_header_o, req_header_i[m_win*HW +: HW]);
                chk("cmd_data", io_cmd_data_o, req_data_i[m_win*DW +: DW]);
            end
            exp_y = (exp_v && yumi_en) ? N'(1 << m_win) : '0;
            chk("yumi", req_yumi_o, exp_y);
            if (m_q.size() == 0) begin
                exp_rv = '0;
                exp_rr = 1'b1;
            end else begin
                exp_rv = io_resp_v_i ? N'(1 << m_q[0]) : '0;
                exp_rr = bit_of(req_resp_ready_i, m_q[0]);
                if (io_resp_v_i) chk("resp_hdr", req_resp_header_o, io_resp_header_i);
            end
            chk("resp_v", req_resp_v_o, exp_rv);
            chk("resp_ready", io_resp_ready_o, exp_rr);
            chk("credits", credits_o, m_q.size());
            chk("idle", idle_o, (m_q.size() == 0) && !m_locked);
            chk("error", error_o, m_err);
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_v_i[i] = pend[i] > 0;
            req_header_i[i*HW +: HW] = HW'((i << 8) | (seq[i] & 255));
            req_data_i[i*DW +: DW]   = DW'(32'hA000_0000 | (i << 16) | seq[i]);
        end
        io_resp_v_i      = resp_pend > 0;
        io_resp_header_i = HW'(16'h5000 | resp_seq);
        io_resp_data_i   = DW'(32'hD000_0000 | resp_seq);
    endtask

    // One clock: observe handshakes mid-period, then retire them after the edge.
    task automatic cycle();
        logic [N-1:0] ys;
        logic [N-1:0] rv;
        bit hs;
        @(negedge clk);
        ys = req_yumi_o;
        rv = req_resp_v_o;
        hs = io_resp_v_i && io_resp_ready_o;
        if (int'(credits_o) > peak) peak = int'(credits_o);
        if (req_yumi_o[1]) y1_seen = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (ys[i]) begin
                grant_log.push_back(i);
                $display("cmd  req %0d hdr %h credits %0d", i, io_cmd_header_o, credits_o);
            end
        end
        if (hs) begin
            owner_log.push_back(rv == 2'b01 ? 0 : (rv == 2'b10 ? 1 : -1));
            $display("resp mask %b hdr %h credits %0d", rv, io_resp_header_i, credits_o);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (ys[i]) begin
                pend[i]--;
                seq[i]++;
            end
        end
        if (hs && resp_pend > 0) begin
            resp_pend--;
            resp_seq++;
        end
        drive();
    endtask

    task automatic wait_pend(input int i, input string name);
        for (int k = 0; k < 60 && pend[i] != 0; k++) cycle();
        chk(name, pend[i], 0);
    endtask

    task automatic wait_resp(input string name);
        for (int k = 0; k < 60 && resp_pend != 0; k++) cycle();
        chk(name, resp_pend, 0);
    endtask

    initial begin
        int exp_g[4];
        int exp_o[3];
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            seq[i]  = 0;
        end
        reset_n_i        = 1'b1;
        yumi_en          = 1'b0;
        req_resp_ready_i = '1;
        drive();
        #1 reset_n_i = 1'b0;
        #2 run = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_credits", credits_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_resp_ready", io_resp_ready_o, 1);
        chk("rst_cmd_v", io_cmd_v_o, 0);
        reset_n_i = 1'b1;
        yumi_en   = 1'b1;

        // Single requester: four commands, then four responses.
        pend[0] = 4;
        drive();
        wait_pend(0, "t2_issue_timeout");
        cycle();
        chk("t2_peak", peak, 4);
        owner_log.delete();
        resp_pend = 4;
        drive();
        wait_resp("t2_resp_timeout");
        cycle();
        chk("t2_credits_end", credits_o, 0);
        chk("t2_no_yumi1", y1_seen, 0);
        chk("t2_owner_count", owner_log.size(), 4);
        foreach (owner_log[k]) chk("t2_owner", owner_log[k], 0);

        // Reset mid-traffic with three outstanding commands.
        pend[1] = 3;
        drive();
        wait_pend(1, "t1_issue_timeout");
        cycle();
        chk("t1_credits_before", credits_o, 3);
        reset_n_i = 1'b0;
        #1;
        chk("t1_credits", credits_o, 0);
        chk("t1_idle", idle_o, 1);
        chk("t1_cmd_v", io_cmd_v_o, 0);
        chk("t1_error", error_o, 0);
        cycle();
        reset_n_i = 1'b1;

        // Contention: both requesters valid, downstream always accepting.
        grant_log.delete();
        pend[0] = 2;
        pend[1] = 2;
        drive();
        for (int k = 0; k < 60 && (pend[0] != 0 || pend[1] != 0); k++) cycle();
        chk("t3_issue_timeout", pend[0] + pend[1], 0);
`ifdef BP_IO_CMD_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 1, 1};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        chk("t3_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("t3_grant", grant_log[k], exp_g[k]);
        resp_pend = 4;
        drive();
        wait_resp("t3_resp_timeout");
        cycle();
        chk("t3_credits_end", credits_o, 0);

        // Credit limit: one more command than credits, no responses yet.
        pend[0] = MAX + 1;
        drive();
        repeat (20) cycle();
        chk("t4_full_credits", credits_o, MAX);
        chk("t4_cmd_blocked", io_cmd_v_o, 0);
        chk("t4_one_waiting", pend[0], 1);
        resp_pend = 1;
        drive();
        wait_resp("t4_resp_timeout");
        chk("t4_credit_freed", credits_o, MAX - 1);
        wait_pend(0, "t4_issue_timeout");
        cycle();
        chk("t4_refilled", credits_o, MAX);
        resp_pend = MAX;
        drive();
        wait_resp("t4_drain_timeout");
        cycle();
        chk("t4_credits_end", credits_o, 0);

        // Routing with backpressure: issue order 1,0,1.
        pend[1] = 1;
        drive();
        wait_pend(1, "t5_a_timeout");
        pend[0] = 1;
        drive();
        wait_pend(0, "t5_b_timeout");
        pend[1] = 1;
        drive();
        wait_pend(1, "t5_c_timeout");
        cycle();
        chk("t5_credits", credits_o, 3);
        owner_log.delete();
        req_resp_ready_i = 2'b01;
        resp_pend = 1;
        drive();
        repeat (3) cycle();
        chk("t5_bp_ready", io_resp_ready_o, 0);
        chk("t5_bp_resp_v", req_resp_v_o, 2'b10);
        chk("t5_bp_no_pop", credits_o, 3);
        req_resp_ready_i = 2'b11;
        wait_resp("t5_r1_timeout");
        resp_pend = 2;
        drive();
        wait_resp("t5_r2_timeout");
        cycle();
        exp_o = '{1, 0, 1};
        chk("t5_owner_count", owner_log.size(), 3);
        for (int k = 0; k < 3; k++) chk("t5_owner", owner_log[k], exp_o[k]);
        chk("t5_credits_end", credits_o, 0);

        // Same-cycle issue and response at one credit, then a stray response.
        pend[0] = 1;
        drive();
        wait_pend(0, "t6_a_timeout");
        cycle();
        chk("t6_credits_one", credits_o, 1);
        yumi_en = 1'b0;
        pend[1] = 1;
        drive();
        for (int k = 0; k < 20 && !io_cmd_v_o; k++) cycle();
        chk("t6_presenting", io_cmd_v_o, 1);
        yumi_en   = 1'b1;
        resp_pend = 1;
        drive();
        cycle();
        chk("t6_issued", pend[1], 0);
        chk("t6_responded", resp_pend, 0);
        chk("t6_credits_same", credits_o, 1);
        resp_pend = 1;
        drive();
        wait_resp("t6_drain_timeout");
        chk("t6_credits_zero", credits_o, 0);
        chk("t6_no_error_yet", error_o, 0);
        resp_pend = 1;
        drive();
        wait_resp("t6_stray_timeout");
        chk("t6_error_set", error_o, 1);
        repeat (3) cycle();
        chk("t6_error_sticky", error_o, 1);
        chk("t6_credits_stay", credits_o, 0);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_io_cmd_arbiter.md
Name: bp_io_cmd_arbiter

Overview:
- Shares one BedRock I/O command/response port between num_req_p requesters, e.g. the stream NBF loader (req 0) and a host debug bridge (req 1).
- Arbitrates single-beat commands round-robin with a grant lock.
- Enforces the io_noc credit limit and steers in-order responses back to the requester that issued each command.
- Sits between the requesters and the I/O network link.

Parameters:
- num_req_p, 2: number of requesters; legal range 2..8.
- header_width_p, mem_header_width_lp: BedRock mem header width.
- data_width_p, cce_block_width_p: command/response data width.
- max_credits_p, io_noc_max_credits_p: maximum outstanding commands; also the route FIFO depth.
- lg_req_lp (localparam), BSG_SAFE_CLOG2(num_req_p): requester id width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- req_header_i  in  num_req_p*header_width_p  per-requester command header.
- req_data_i  in  num_req_p*data_width_p  per-requester command data.
- req_v_i  in  num_req_p  per-requester command valid.
- req_yumi_o  out  num_req_p  command accepted; one-hot or zero.
- req_resp_header_o  out  header_width_p  response header, broadcast to all requesters.
- req_resp_data_o  out  data_width_p  response data, broadcast.
- req_resp_v_o  out  num_req_p  response valid for the owning requester.
- req_resp_ready_i  in  num_req_p  requester response ready.
- io_cmd_header_o  out  header_width_p  muxed command header.
- io_cmd_data_o  out  data_width_p  muxed command data.
- io_cmd_v_o  out  1  command valid.
- io_cmd_yumi_i  in  1  downstream consumes command.
- io_resp_header_i  in  header_width_p  response header.
- io_resp_data_i  in  data_width_p  response data.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  response ready.
- credits_o  out  BSG_WIDTH(max_credits_p)  outstanding command count.
- idle_o  out  1  no outstanding commands and no locked grant.
- error_o  out  1  sticky: a response arrived with no outstanding command.

Behaviour:
- Async reset (reset_n_i low):
  - All state cleared: lock, grant, route FIFO, credits = 0, error = 0, round-robin pointer = 0.
  - All outputs 0 except idle_o = 1 and io_resp_ready_o = 1.
  - Outstanding transactions are discarded. Release is synchronous to clk_i via the system reset synchronizer.
- can_issue = credits_o != max_credits_p AND route FIFO not full.
- FSM e_idle / e_locked:
  - e_idle:
    - If any req_v_i and can_issue: pick the winner round-robin, starting at the index after the last granted requester.
    - Register the winner and go to e_locked. No command is presented in the arbitration cycle, so latency is 1 cycle from req_v to io_cmd_v.
  - e_locked:
    - io_cmd_v_o = req_v_i[winner] AND can_issue. Header and data are muxed from the winner.
    - On io_cmd_yumi_i in the same cycle:
      - req_yumi_o[winner] = 1;
      - push winner id into the route FIFO;
      - credits +1;
      - advance the pointer to winner+1 (mod num_req_p);
      - return to e_idle.
    - The winner is never changed while locked, even if other requesters raise valid. A requester dropping valid while locked is a protocol violation (assertion).
- Credits: io_cmd_yumi_i and a response handshake in the same cycle leave credits unchanged. Credits never exceed max_credits_p and never wrap below 0.
- Responses:
  - Responses are in order. The head of the route FIFO selects the owner.
  - req_resp_v_o[head] = io_resp_v_i; io_resp_ready_o = req_resp_ready_i[head].
  - Handshake pops the FIFO and decrements credits.
  - If the FIFO is empty: io_resp_ready_o = 1, the response is dropped, error_o is set until reset, and credits stay 0.
- idle_o = (credits_o == 0) AND state == e_idle. A same-cycle push and pop on a full FIFO is legal.

Optional Feature:
BP_IO_CMD_ARB_FIXED_PRIO_EN
- Defined: the lowest-index valid requester always wins (loader priority), and the round-robin pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- bp_me_pkg (or a shared I/O package):
  - enum bp_io_arb_state_e {e_idle, e_locked};
  - route-entry width constant.
- Sub-module bp_io_arb_route_fifo:
  - bsg_fifo_1r1w_small wrapper, depth max_credits_p, width lg_req_lp;
  - exposes full/empty and head id.
- The round-robin pointer uses a bsg_arb_round_robin instance.

Test Plan:
1. Reset: hold reset_n_i low mid-traffic with credits = 3 -> the next cycle shows credits_o = 0, idle_o = 1, io_cmd_v_o = 0, error_o = 0.
2. Single requester: req 0 sends 4 commands, each yumi'd 1 cycle after valid; 4 responses return -> req_resp_v_o = 2'b01 each time, credits peak at 4 and end at 0, req_yumi_o[1] is never asserted.
3. Contention: both valid continuously, yumi every cycle -> grants alternate 0,1,0,1; with FIXED_PRIO_EN, always 0.
4. Credit full: max_credits_p = 2, 3 commands with no responses -> io_cmd_v_o drops after 2 yumis. One response reopens the path on the next cycle; credits_o goes 2 -> 1 -> 2.
5. Routing and backpressure: issue order 1,0,1; response for req 1 with req_resp_ready_i[1] = 0 for 3 cycles -> io_resp_ready_o = 0, no pop. Later responses go to 0, then 1.
6. Simultaneous yumi and response at credits = 1 -> credits stay 1. A spurious io_resp_v_i at credits = 0 sets error_o = 1 and it stays set.
